// File: rtl/sccb_write_ctrl_if.sv
// sccb_write_ctrl_if: request, status and SCCB pad signals of the SCCB write controller
interface sccb_write_ctrl_if;
    logic       SCCB_CLK;
    logic       SCCB_MID_PULSE;
    logic       START;
    logic [7:0] REG_ADDR;
    logic [7:0] REG_DATA;
    logic       SIO_D_IN;
    logic       SIO_C;
    logic       SIO_D_OUT;
    logic       SIO_D_OE;
    logic       BUSY;
    logic       DONE;
    logic       ACK_ERR;

    // controller view: the SCCB master driving the pads
    modport master (
        input  SCCB_CLK, SCCB_MID_PULSE, START, REG_ADDR, REG_DATA, SIO_D_IN,
        output SIO_C, SIO_D_OUT, SIO_D_OE, BUSY, DONE, ACK_ERR
    );

    // counterpart view: requester, clock divider and pad model
    modport slave (
        output SCCB_CLK, SCCB_MID_PULSE, START, REG_ADDR, REG_DATA, SIO_D_IN,
        input  SIO_C, SIO_D_OUT, SIO_D_OE, BUSY, DONE, ACK_ERR
    );
endinterface

// File: rtl/sccb_write_ctrl.sv
// sccb_write_ctrl: 3-phase SCCB write (ID, sub-address, data) with start/stop conditions
module sccb_write_ctrl #(
    parameter logic [7:0] DEV_ADDR = 8'h42
) (
    input logic               PCLK,
    input logic               PRESETN,
    sccb_write_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, START_C, TX, STOP_LO, STOP_WAIT, STOP_HI} state_t;

    state_t     state, state_n;
    logic       sio_c, sio_c_n, sio_d, sio_d_n, oe, oe_n, busy, busy_n, done, done_n;
    logic       ack_err, ack_err_n, gate, gate_n, started, started_n, clk_q;
    logic [3:0] bit_cnt, bit_cnt_n, nxt_bit;
    logic [1:0] byte_cnt, byte_cnt_n, nxt_byte, sel_byte;
    logic [2:0] sel_bit;
    logic [7:0] addr_q, addr_n, data_q, data_n, sel_val;
    logic       tx_bit, rise, last_slot;

    assign rise      = bus.SCCB_CLK & ~clk_q;
    assign last_slot = byte_cnt == 2'd2 && bit_cnt == 4'd8;
    assign nxt_bit   = bit_cnt == 4'd8 ? 4'd0 : bit_cnt + 4'd1;
    assign nxt_byte  = bit_cnt == 4'd8 ? byte_cnt + 2'd1 : byte_cnt;
    // the bit to drive is the one of the slot being entered; START_C enters slot 0
    assign sel_bit   = state == TX ? nxt_bit[2:0] : 3'd0;
    assign sel_byte  = state == TX ? nxt_byte : 2'd0;
    assign sel_val   = sel_byte == 2'd0 ? DEV_ADDR : sel_byte == 2'd1 ? addr_q : data_q;
    assign tx_bit    = sel_val[3'd7 - sel_bit];

    assign bus.SIO_C     = sio_c;
    assign bus.SIO_D_OUT = sio_d;
    assign bus.SIO_D_OE  = oe;
    assign bus.BUSY      = busy;
    assign bus.DONE      = done;
    assign bus.ACK_ERR   = ack_err;

    // state and registered outputs; reset aborts any frame without a stop condition
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state    <= IDLE;
            sio_c    <= 1'b1;
            sio_d    <= 1'b1;
            oe       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            gate     <= 1'b0;
            started  <= 1'b0;
            clk_q    <= 1'b0;
            bit_cnt  <= 4'd0;
            byte_cnt <= 2'd0;
            addr_q   <= 8'd0;
            data_q   <= 8'd0;
        end else begin
            state    <= state_n;
            sio_c    <= sio_c_n;
            sio_d    <= sio_d_n;
            oe       <= oe_n;
            busy     <= busy_n;
            done     <= done_n;
            ack_err  <= ack_err_n;
            gate     <= gate_n;
            started  <= started_n;
            clk_q    <= bus.SCCB_CLK;
            bit_cnt  <= bit_cnt_n;
            byte_cnt <= byte_cnt_n;
            addr_q   <= addr_n;
            data_q   <= data_n;
        end
    end

    // next state and next output values; SIO_C follows SCCB_CLK only while gated
    always_comb begin
        state_n    = state;
        sio_d_n    = sio_d;
        oe_n       = oe;
        busy_n     = busy;
        done_n     = 1'b0;
        ack_err_n  = ack_err;
        gate_n     = gate;
        started_n  = started;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        addr_n     = addr_q;
        data_n     = data_q;
        case (state)
            IDLE: if (bus.START) begin
                addr_n     = bus.REG_ADDR;
                data_n     = bus.REG_DATA;
                ack_err_n  = 1'b0;
                busy_n     = 1'b1;
                started_n  = 1'b0;
                bit_cnt_n  = 4'd0;
                byte_cnt_n = 2'd0;
                state_n    = START_C;
            end
            START_C: if (bus.SCCB_MID_PULSE) begin
                if (!started) begin
                    started_n = 1'b1;
                    sio_d_n   = 1'b0;
                end else begin
                    gate_n  = 1'b1;
                    sio_d_n = tx_bit;
                    oe_n    = 1'b1;
                    state_n = TX;
                end
            end
            TX: begin
                if (rise && bit_cnt == 4'd8 && bus.SIO_D_IN) ack_err_n = 1'b1;
                if (bus.SCCB_MID_PULSE) begin
                    if (last_slot) begin
                        sio_d_n    = 1'b0;
                        oe_n       = 1'b1;
                        bit_cnt_n  = 4'd0;
                        byte_cnt_n = 2'd0;
                        state_n    = STOP_LO;
                    end else begin
                        bit_cnt_n  = nxt_bit;
                        byte_cnt_n = nxt_byte;
                        oe_n       = nxt_bit != 4'd8;
                        sio_d_n    = nxt_bit == 4'd8 ? 1'b1 : tx_bit;
                    end
                end
            end
            STOP_LO: if (bus.SCCB_CLK) begin
                gate_n  = 1'b0;
                state_n = STOP_WAIT;
            end
            STOP_WAIT: if (bus.SCCB_MID_PULSE) begin
                sio_d_n = 1'b1;
                state_n = STOP_HI;
            end
            STOP_HI: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        sio_c_n = gate_n ? bus.SCCB_CLK : 1'b1;
    end
endmodule

// File: tb/tb_sccb_write_ctrl.sv
// tb_sccb_write_ctrl: directed self-checking bench for the SCCB write controller
module tb_sccb_write_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    sccb_write_ctrl_if bus();
    sccb_write_ctrl #(.DEV_ADDR(8'h42)) dut (.PCLK(clk), .PRESETN(rstn), .bus(bus.master));

    always #5 clk = ~clk;

    logic [1:0] cap [0:31];
    int   rises = 0, done_cnt = 0, viol = 0, cyc = 0, start_t = 0, stop_t = 0, div_c = 0;
    bit   in_frame = 0, start_seen = 0, stop_seen = 0, mon_en = 0;
    logic [3:0] ack_mask = 4'd0;
    logic pc = 1'b1, pd = 1'b1;

    // divider model (period 8 PCLK, mid-low pulse) and pad model answering don't-care slots
    initial begin
        bus.SCCB_CLK = 0; bus.SCCB_MID_PULSE = 0; bus.SIO_D_IN = 0;
        forever begin
            @(negedge clk);
            div_c = (div_c + 1) % 8;
            bus.SCCB_CLK = div_c >= 4;
            bus.SCCB_MID_PULSE = div_c == 1;
            bus.SIO_D_IN = !bus.SIO_D_OE && ack_mask[rises / 9];
        end
    end

    // bus monitor: start/stop detection, slot capture on SIO_C rise, SIO_D-stability and idle checks
    initial forever begin
        @(posedge clk); #1;
        cyc++;
        if (bus.DONE) done_cnt++;
        if (mon_en) begin
            if (pc && bus.SIO_C && pd && !bus.SIO_D_OUT && !in_frame) begin
                in_frame = 1; rises = 0; start_seen = 1; stop_seen = 0; start_t = cyc;
            end else if (pc && bus.SIO_C && !pd && bus.SIO_D_OUT && in_frame && rises == 28) begin
                in_frame = 0; stop_seen = 1; stop_t = cyc;
            end else if (pc && bus.SIO_C && pd != bus.SIO_D_OUT) viol++;
            if (!pc && bus.SIO_C && in_frame) begin
                if (rises < 32) cap[rises] = {bus.SIO_D_OE, bus.SIO_D_OUT};
                rises++;
            end
            if (!bus.BUSY && !(bus.SIO_C && bus.SIO_D_OUT && bus.SIO_D_OE)) viol++;
        end else in_frame = 0;
        pc = bus.SIO_C; pd = bus.SIO_D_OUT;
    end

    function automatic logic [1:0] exp_slot(input logic [7:0] a, input logic [7:0] d, input int i);
        logic [7:0] b;
        b = i / 9 == 0 ? 8'h42 : i / 9 == 1 ? a : d;
        return i % 9 == 8 ? 2'b00 : {1'b1, b[7 - i % 9]};
    endfunction

    task automatic kick(input logic [7:0] a, input logic [7:0] d, input logic hold);
        @(negedge clk);
        bus.REG_ADDR = a; bus.REG_DATA = d; bus.START = 1; done_cnt = 0; rises = 0;
        @(negedge clk);
        bus.START = hold;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clk); #1;
            ok = bus.DONE;
        end
    endtask

    task automatic test_reset;
        bus.START = 0; bus.REG_ADDR = 0; bus.REG_DATA = 0;
        rstn = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.SIO_C, bus.SIO_D_OUT, bus.SIO_D_OE, bus.BUSY, bus.DONE, bus.ACK_ERR} !== 6'b111000) begin
            failures++;
            $display("FAIL reset_held: got %b want 111000", {bus.SIO_C, bus.SIO_D_OUT, bus.SIO_D_OE, bus.BUSY, bus.DONE, bus.ACK_ERR});
        end
        rstn = 1;
        repeat (4) @(negedge clk);
        mon_en = 1;
        checks++;
        if ({bus.SIO_C, bus.SIO_D_OUT, bus.SIO_D_OE, bus.BUSY, bus.DONE, bus.ACK_ERR} !== 6'b111000) begin
            failures++;
            $display("FAIL reset_idle: got %b want 111000", {bus.SIO_C, bus.SIO_D_OUT, bus.SIO_D_OE, bus.BUSY, bus.DONE, bus.ACK_ERR});
        end
    endtask

    task automatic test_basic;
        bit ok;
        int k;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.SCCB_MID_PULSE) break;
        end
        bus.REG_ADDR = 8'h12; bus.REG_DATA = 8'h80; bus.START = 1; done_cnt = 0; rises = 0;
        @(posedge clk); #1;
        bus.START = 0;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(posedge clk); #1;
            if (!bus.SIO_D_OUT) k = i;
        end
        checks++;
        if (k !== 8) begin failures++; $display("FAIL start_latency: got %0d want 8", k); end
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_done_timeout: got 0 want 1"); end
        repeat (10) @(negedge clk);
        checks++;
        if (rises !== 28) begin failures++; $display("FAIL basic_rises: got %0d want 28", rises); end
        for (int i = 0; i < 27; i++) begin
            logic [1:0] e;
            e = exp_slot(8'h12, 8'h80, i);
            checks++;
            if (cap[i][1] !== e[1] || (e[1] && cap[i][0] !== e[0])) begin
                failures++; $display("FAIL basic_slot%0d: got %b want %b", i, cap[i], e);
            end
        end
        checks++;
        if (cap[27] !== 2'b10) begin failures++; $display("FAIL basic_stop_setup: got %b want 10", cap[27]); end
        checks++;
        if ({start_seen, stop_seen} !== 2'b11) begin failures++; $display("FAIL basic_start_stop: got %b want 11", {start_seen, stop_seen}); end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        checks++;
        if ({bus.ACK_ERR, bus.BUSY} !== 2'b00) begin failures++; $display("FAIL basic_ack_busy: got %b want 00", {bus.ACK_ERR, bus.BUSY}); end
        checks++;
        if (viol !== 0) begin failures++; $display("FAIL basic_bus_rules: got %0d want 0", viol); end
    endtask

    task automatic test_ack_err;
        bit ok;
        ack_mask = 4'b0010;
        kick(8'h12, 8'h80, 0);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ack_done_timeout: got 0 want 1"); end
        repeat (10) @(negedge clk);
        ack_mask = 4'b0000;
        checks++;
        if (bus.ACK_ERR !== 1'b1) begin failures++; $display("FAIL ack_err_set: got %b want 1", bus.ACK_ERR); end
        for (int i = 0; i < 27; i++) begin
            logic [1:0] e;
            e = exp_slot(8'h12, 8'h80, i);
            checks++;
            if (cap[i][1] !== e[1] || (e[1] && cap[i][0] !== e[0])) begin
                failures++; $display("FAIL ack_slot%0d: got %b want %b", i, cap[i], e);
            end
        end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL ack_done_count: got %0d want 1", done_cnt); end
        checks++;
        if (viol !== 0) begin failures++; $display("FAIL ack_bus_rules: got %0d want 0", viol); end
    endtask

    task automatic test_ignore;
        bit ok;
        kick(8'h5A, 8'hC3, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.ACK_ERR, bus.BUSY} !== 2'b01) begin failures++; $display("FAIL ign_accept: got %b want 01", {bus.ACK_ERR, bus.BUSY}); end
        for (int i = 0; i < 500 && rises < 10; i++) @(negedge clk);
        bus.REG_ADDR = 8'hFF; bus.REG_DATA = 8'h00; bus.START = 1;
        @(negedge clk);
        bus.START = 0;
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ign_done_timeout: got 0 want 1"); end
        repeat (40) @(negedge clk);
        for (int i = 0; i < 27; i++) begin
            logic [1:0] e;
            e = exp_slot(8'h5A, 8'hC3, i);
            checks++;
            if (cap[i][1] !== e[1] || (e[1] && cap[i][0] !== e[0])) begin
                failures++; $display("FAIL ign_slot%0d: got %b want %b", i, cap[i], e);
            end
        end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
        checks++;
        if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL ign_busy_after: got %b want 0", bus.BUSY); end
        checks++;
        if (viol !== 0) begin failures++; $display("FAIL ign_bus_rules: got %0d want 0", viol); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        kick(8'h12, 8'h80, 0);
        for (int i = 0; i < 500 && rises < 15; i++) @(negedge clk);
        mon_en = 0;
        #2 rstn = 0;
        #1;
        checks++;
        if ({bus.SIO_C, bus.SIO_D_OUT, bus.SIO_D_OE, bus.BUSY, bus.DONE, bus.ACK_ERR} !== 6'b111000) begin
            failures++;
            $display("FAIL rmid_async: got %b want 111000", {bus.SIO_C, bus.SIO_D_OUT, bus.SIO_D_OE, bus.BUSY, bus.DONE, bus.ACK_ERR});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.SIO_C, bus.SIO_D_OUT, bus.SIO_D_OE, bus.BUSY, bus.DONE, bus.ACK_ERR} !== 6'b111000) begin
            failures++;
            $display("FAIL rmid_next: got %b want 111000", {bus.SIO_C, bus.SIO_D_OUT, bus.SIO_D_OE, bus.BUSY, bus.DONE, bus.ACK_ERR});
        end
        checks++;
        if (done_cnt !== 0) begin failures++; $display("FAIL rmid_no_done: got %0d want 0", done_cnt); end
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        mon_en = 1;
        kick(8'h34, 8'h56, 0);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rmid_done_timeout: got 0 want 1"); end
        repeat (10) @(negedge clk);
        checks++;
        if (rises !== 28) begin failures++; $display("FAIL rmid_rises: got %0d want 28", rises); end
        for (int i = 0; i < 27; i++) begin
            logic [1:0] e;
            e = exp_slot(8'h34, 8'h56, i);
            checks++;
            if (cap[i][1] !== e[1] || (e[1] && cap[i][0] !== e[0])) begin
                failures++; $display("FAIL rmid_slot%0d: got %b want %b", i, cap[i], e);
            end
        end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL rmid_done_count: got %0d want 1", done_cnt); end
        checks++;
        if (viol !== 0) begin failures++; $display("FAIL rmid_bus_rules: got %0d want 0", viol); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int gap;
        kick(8'hA1, 8'hB2, 1);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_done1_timeout: got 0 want 1"); end
        checks++;
        if (rises !== 28) begin failures++; $display("FAIL b2b_rises1: got %0d want 28", rises); end
        for (int i = 0; i < 27; i++) begin
            logic [1:0] e;
            e = exp_slot(8'hA1, 8'hB2, i);
            checks++;
            if (cap[i][1] !== e[1] || (e[1] && cap[i][0] !== e[0])) begin
                failures++; $display("FAIL b2b1_slot%0d: got %b want %b", i, cap[i], e);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL b2b_restart: got %b want 1", bus.BUSY); end
        @(negedge clk);
        bus.START = 0;
        for (int i = 0; i < 40 && !in_frame; i++) @(negedge clk);
        gap = start_t - stop_t;
        checks++;
        if (gap < 8) begin failures++; $display("FAIL b2b_idle_gap: got %0d want >=8", gap); end
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_done2_timeout: got 0 want 1"); end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 27; i++) begin
            logic [1:0] e;
            e = exp_slot(8'hA1, 8'hB2, i);
            checks++;
            if (cap[i][1] !== e[1] || (e[1] && cap[i][0] !== e[0])) begin
                failures++; $display("FAIL b2b2_slot%0d: got %b want %b", i, cap[i], e);
            end
        end
        checks++;
        if (done_cnt !== 2) begin failures++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
        checks++;
        if (viol !== 0) begin failures++; $display("FAIL b2b_bus_rules: got %0d want 0", viol); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_ack_err;
        test_ignore;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
